csi2_pkt_parser_4ln: RTL and testbench

- CSI-2 receive-side packet parser for a 4-lane, gear8 byte stream; the inverse of the transmit-side header/payload builder.
- Input is lane-aligned 32-bit words from the D-PHY RX word aligner.
- Extracts VC/DT/WC from the packet header, checks and corrects the header ECC, and strips the header and 2-byte CRC footer.
- Emits payload words with byte enables to the downstream byte2pixel stage.

---
 rtl/csi2_pkg.sv | 48 ++++
 rtl/csi2_hdr_ecc.sv | 47 ++++
 rtl/csi2_pkt_parser_4ln.sv | 207 ++++++++++++++++++++
 tb/tb_csi2_pkt_parser_4ln.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared definitions for the CSI-2 receive packet parser: data-type limits,
// header ECC column masks, FSM state codes, header layout and the CRC-16 step.
// The optional CRC checker is enabled with CSI2_RX_CRC_CHECK_EN.
package csi2_pkg;

    // Data types below this value are short packets.
    localparam logic [5:0] DT_SP_LIMIT = 6'h10;
    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;

    // Parity contribution of each header data bit D0..D23, as {P5..P0}.
    // Every column has odd weight, so a double-bit error never aliases a
    // single-bit one.
    localparam logic [0:23][5:0] ECC_COL = {
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    // Parser states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PYLD  = 2'd1;
    localparam logic [1:0] ST_CRC   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // x^16+x^12+x^5+1 processed LSB first, i.e. the bit-reversed polynomial.
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

    // The 24 protected header bits, in wire order {WC_H, WC_L, DI}.
    typedef struct packed {
        logic [15:0] wc;
        logic [1:0]  vc;
        logic [5:0]  dt;
    } pkt_hdr_t;

    // Advance the CRC by one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else             c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_hdr_ecc.sv
// Combinational CSI-2 header ECC: syndrome, single-bit correction and
// uncorrectable-error detection over 24 data bits + 6 ECC bits.
module csi2_hdr_ecc
    import csi2_pkg::*;
(
    input  logic [23:0] data,
    input  logic [5:0]  ecc,
    output logic [23:0] data_fix,
    output logic        corr,
    output logic        err
);

    logic [5:0] calc;
    logic [5:0] syn;

    // Recompute parity from the received data bits.
    always_comb begin
        calc = '0;
        for (int i = 0; i < 24; i++)
            if (data[i]) calc = calc ^ ECC_COL[i];
    end

    assign syn = calc ^ ecc;

    // Classify the syndrome: clean, ECC-byte hit, data-bit hit, or fatal.
    always_comb begin
        data_fix = data;
        corr     = 1'b0;
        err      = 1'b0;
        if (syn != 6'd0) begin
            if ($onehot(syn)) begin
                // The flipped bit sits in the ECC byte; data is already good.
                corr = 1'b1;
            end else begin
                err = 1'b1;
                for (int i = 0; i < 24; i++) begin
                    if (syn == ECC_COL[i]) begin
                        data_fix[i] = ~data[i];
                        corr        = 1'b1;
                        err         = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/csi2_pkt_parser_4ln.sv
// CSI-2 RX packet parser, 4 lanes x 8 bits. Decodes and ECC-corrects the
// packet header, strips header and CRC footer, and emits payload words with
// contiguous byte enables. Define CSI2_RX_CRC_CHECK_EN to add the payload
// CRC-16 checker and its crc_err_o output.
module csi2_pkt_parser_4ln
    import csi2_pkg::*;
#(
    parameter int PP_DATA_WIDTH = 8,   // only 8 is supported
    parameter int LANES         = 4    // fixed at 4
)(
    input  logic                           core_clk_i,
    input  logic                           core_rst_i,
    input  logic [LANES*PP_DATA_WIDTH-1:0] byte_data_i,
    input  logic                           byte_data_en_i,
    output logic                           hdr_vld_o,
    output logic [1:0]                     vc_o,
    output logic [5:0]                     dt_o,
    output logic [15:0]                    wc_o,
    output logic                           sp_o,
    output logic                           ecc_corr_o,
    output logic                           ecc_err_o,
    output logic [LANES*PP_DATA_WIDTH-1:0] pyld_data_o,
    output logic [LANES-1:0]               pyld_be_o,
    output logic                           pyld_vld_o,
    output logic                           pyld_last_o,
    output logic [15:0]                    crc_rcv_o,
    output logic                           pkt_done_o,
    output logic                           trunc_err_o
`ifdef CSI2_RX_CRC_CHECK_EN
    ,
    output logic                           crc_err_o
`endif
);

    logic [LANES-1:0][PP_DATA_WIDTH-1:0] lane;
    logic [1:0]       state;
    logic             en_q;
    logic             en_rise;
    logic [15:0]      rem;
    logic [7:0]       crc_lo;
    logic             crc_two;
    logic [LANES-1:0] be_cur;
    logic [15:0]      crc_pyld;
    logic [15:0]      crc_tail;
    pkt_hdr_t         hdr_raw;
    pkt_hdr_t         hdr_fix;
    logic             hdr_corr;
    logic             hdr_err;

    assign lane    = byte_data_i;
    assign en_rise = byte_data_en_i & ~en_q;
    assign hdr_raw = byte_data_i[23:0];

    csi2_hdr_ecc u_ecc (
        .data     (hdr_raw),
        .ecc      (byte_data_i[29:24]),
        .data_fix (hdr_fix),
        .corr     (hdr_corr),
        .err      (hdr_err)
    );

    // Byte enables for the current payload word from the remaining count.
    always_comb begin
        be_cur = 4'b0000;
        if (rem >= 16'd4)      be_cur = 4'b1111;
        else if (rem == 16'd3) be_cur = 4'b0111;
        else if (rem == 16'd2) be_cur = 4'b0011;
        else if (rem == 16'd1) be_cur = 4'b0001;
    end

    // CRC as seen on the wire: inside the last payload word (rem 1/2), or in
    // the word after it (lanes 0/1, or lane 0 plus a low byte kept from lane 3).
    assign crc_pyld = (rem == 16'd1) ? {lane[2], lane[1]} : {lane[3], lane[2]};
    assign crc_tail = crc_two ? {lane[1], lane[0]} : {lane[0], crc_lo};

`ifdef CSI2_RX_CRC_CHECK_EN
    logic [15:0] crc_acc;
    logic [15:0] crc_next;

    // Fold the enabled payload bytes of this word into the running CRC.
    always_comb begin
        crc_next = crc_acc;
        for (int k = 0; k < LANES; k++)
            if (be_cur[k]) crc_next = crc16_byte(crc_next, lane[k]);
    end
`endif

    // Packet FSM with registered header, payload and status outputs.
    always_ff @(posedge core_clk_i or posedge core_rst_i) begin
        if (core_rst_i) begin
            state       <= ST_IDLE;
            en_q        <= 1'b0;
            rem         <= '0;
            crc_lo      <= '0;
            crc_two     <= 1'b0;
            hdr_vld_o   <= 1'b0;
            vc_o        <= '0;
            dt_o        <= '0;
            wc_o        <= '0;
            sp_o        <= 1'b0;
            ecc_corr_o  <= 1'b0;
            ecc_err_o   <= 1'b0;
            pyld_data_o <= '0;
            pyld_be_o   <= '0;
            pyld_vld_o  <= 1'b0;
            pyld_last_o <= 1'b0;
            crc_rcv_o   <= '0;
            pkt_done_o  <= 1'b0;
            trunc_err_o <= 1'b0;
`ifdef CSI2_RX_CRC_CHECK_EN
            crc_acc     <= CRC_INIT;
            crc_err_o   <= 1'b0;
`endif
        end else begin
            en_q        <= byte_data_en_i;
            hdr_vld_o   <= 1'b0;
            pyld_vld_o  <= 1'b0;
            pyld_last_o <= 1'b0;
            pyld_be_o   <= '0;
            pkt_done_o  <= 1'b0;
            trunc_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_rise) begin
                        hdr_vld_o  <= 1'b1;
                        vc_o       <= hdr_fix.vc;
                        dt_o       <= hdr_fix.dt;
                        wc_o       <= hdr_fix.wc;
                        sp_o       <= (hdr_fix.dt < DT_SP_LIMIT);
                        ecc_corr_o <= hdr_corr;
                        ecc_err_o  <= hdr_err;
`ifdef CSI2_RX_CRC_CHECK_EN
                        crc_acc    <= CRC_INIT;
                        crc_err_o  <= 1'b0;
`endif
                        // Short and unreadable packets carry no CRC, so
                        // crc_rcv_o keeps its previous value for them.
                        if (hdr_err || (hdr_fix.dt < DT_SP_LIMIT)) begin
                            pkt_done_o <= 1'b1;
                            state      <= ST_DRAIN;
                        end else if (hdr_fix.wc == 16'd0) begin
                            rem     <= '0;
                            crc_two <= 1'b1;
                            state   <= ST_CRC;
                        end else begin
                            rem   <= hdr_fix.wc;
                            state <= ST_PYLD;
                        end
                    end
                end
                ST_PYLD: begin
                    if (!byte_data_en_i) begin
                        trunc_err_o <= 1'b1;
                        pkt_done_o  <= 1'b1;
                        rem         <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        pyld_vld_o  <= 1'b1;
                        pyld_data_o <= byte_data_i;
                        pyld_be_o   <= be_cur;
`ifdef CSI2_RX_CRC_CHECK_EN
                        crc_acc     <= crc_next;
`endif
                        if (rem > 16'd4) begin
                            rem <= rem - 16'd4;
                        end else begin
                            pyld_last_o <= 1'b1;
                            rem         <= '0;
                            if (rem <= 16'd2) begin
                                crc_rcv_o  <= crc_pyld;
                                pkt_done_o <= 1'b1;
`ifdef CSI2_RX_CRC_CHECK_EN
                                crc_err_o  <= (crc_next != crc_pyld);
`endif
                                state      <= ST_DRAIN;
                            end else begin
                                crc_lo  <= lane[3];
                                crc_two <= (rem == 16'd4);
                                state   <= ST_CRC;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (!byte_data_en_i) begin
                        trunc_err_o <= 1'b1;
                        pkt_done_o  <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        crc_rcv_o  <= crc_tail;
                        pkt_done_o <= 1'b1;
`ifdef CSI2_RX_CRC_CHECK_EN
                        crc_err_o  <= (crc_acc != crc_tail);
`endif
                        state      <= ST_DRAIN;
                    end
                end
                default: begin
                    // Rest of the burst is ignored; a new header needs a fresh
                    // rising edge of the enable.
                    if (!byte_data_en_i) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csi2_pkt_parser_4ln.sv
// Directed self-checking bench for csi2_pkt_parser_4ln. Header ECC bytes are
// hand-computed constants; CRC-check cases are built with
// CSI2_RX_CRC_CHECK_EN defined.
module tb_csi2_pkt_parser_4ln;

    logic        clk;
    logic        rst;
    logic [31:0] byte_data;
    logic        byte_en;
    logic        hdr_vld;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        sp;
    logic        ecc_corr;
    logic        ecc_err;
    logic [31:0] pyld_data;
    logic [3:0]  pyld_be;
    logic        pyld_vld;
    logic        pyld_last;
    logic [15:0] crc_rcv;
    logic        pkt_done;
    logic        trunc_err;
`ifdef CSI2_RX_CRC_CHECK_EN
    logic        crc_err;
`endif

    int errors = 0;
    int checks = 0;

    // Hand-computed headers {ECC, WC_H, WC_L, DI}.
    localparam logic [31:0] H_FS      = 32'h1A000100; // DI 00, WC 1
    localparam logic [31:0] H_FS_EBIT = 32'h1B000100; // ECC bit0 flipped
    localparam logic [31:0] H_RAW10   = 32'h2E000A2B; // DT 2B, WC 10
    localparam logic [31:0] H_WC7     = 32'h3200072B;
    localparam logic [31:0] H_WC8     = 32'h3200082B;
    localparam logic [31:0] H_WC0     = 32'h1700002B;
    localparam logic [31:0] H_WC16    = 32'h3100102B;
    localparam logic [31:0] H_WC4     = 32'h3400042B;
    localparam logic [31:0] H_DI3     = 32'h2E000A23; // DI bit3 flipped
    localparam logic [31:0] H_DBL     = 32'h2E000A28; // DI bits 0,1 flipped

    csi2_pkt_parser_4ln dut (
        .core_clk_i     (clk),
        .core_rst_i     (rst),
        .byte_data_i    (byte_data),
        .byte_data_en_i (byte_en),
        .hdr_vld_o      (hdr_vld),
        .vc_o           (vc),
        .dt_o           (dt),
        .wc_o           (wc),
        .sp_o           (sp),
        .ecc_corr_o     (ecc_corr),
        .ecc_err_o      (ecc_err),
        .pyld_data_o    (pyld_data),
        .pyld_be_o      (pyld_be),
        .pyld_vld_o     (pyld_vld),
        .pyld_last_o    (pyld_last),
        .crc_rcv_o      (crc_rcv),
        .pkt_done_o     (pkt_done),
        .trunc_err_o    (trunc_err)
`ifdef CSI2_RX_CRC_CHECK_EN
        ,
        .crc_err_o      (crc_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Present one word for the next rising edge; outputs seen right after
    // this call reflect the word presented before it.
    task automatic drive(input logic [31:0] w, input logic en);
        @(posedge clk);
        #1;
        byte_data = w;
        byte_en   = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'h0, 1'b0);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({hdr_vld, vc, dt, wc, sp, ecc_corr, ecc_err, pyld_data, pyld_be,
             pyld_vld, pyld_last, crc_rcv, pkt_done, trunc_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero during reset (pyld_data=%h wc=%h)", pyld_data, wc);
        end
        rst = 1'b0;
        idle(2);
        checks++;
        if ({hdr_vld, pyld_vld, pkt_done, trunc_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: got %b want 0000", {hdr_vld, pyld_vld, pkt_done, trunc_err});
        end
    endtask

    task automatic test_short_fs;
        drive(H_FS, 1'b1);
        drive(32'h0, 1'b1);
        checks++;
        if ({hdr_vld, pkt_done, sp, pyld_vld, ecc_corr, ecc_err} !== 6'b111000) begin
            errors++;
            $display("FAIL fs_flags: got %b want 111000", {hdr_vld, pkt_done, sp, pyld_vld, ecc_corr, ecc_err});
        end
        checks++;
        if ({vc, dt, wc} !== {2'd0, 6'h00, 16'h0001}) begin
            errors++;
            $display("FAIL fs_fields: got vc=%0d dt=%h wc=%h want 0 00 0001", vc, dt, wc);
        end
        drive(32'h0, 1'b1);
        checks++;
        if ({hdr_vld, pyld_vld, pkt_done} !== 3'b000) begin
            errors++;
            $display("FAIL fs_after: got %b want 000", {hdr_vld, pyld_vld, pkt_done});
        end
        idle(2);
    endtask

    task automatic test_long_raw10;
        drive(H_RAW10, 1'b1);
        drive(32'h04030201, 1'b1);
        checks++;
        if ({hdr_vld, sp, pkt_done, dt, wc} !== {3'b100, 6'h2B, 16'd10}) begin
            errors++;
            $display("FAIL raw10_hdr: got vld=%b sp=%b done=%b dt=%h wc=%0d want 1 0 0 2b 10", hdr_vld, sp, pkt_done, dt, wc);
        end
        drive(32'h08070605, 1'b1);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pyld_data} !== {1'b1, 4'b1111, 1'b0, 32'h04030201}) begin
            errors++;
            $display("FAIL raw10_w0: got vld=%b be=%b last=%b data=%h", pyld_vld, pyld_be, pyld_last, pyld_data);
        end
        drive(32'hBEEF0A09, 1'b1);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pyld_data} !== {1'b1, 4'b1111, 1'b0, 32'h08070605}) begin
            errors++;
            $display("FAIL raw10_w1: got vld=%b be=%b last=%b data=%h", pyld_vld, pyld_be, pyld_last, pyld_data);
        end
        drive(32'h0, 1'b0);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pkt_done, pyld_data} !== {1'b1, 4'b0011, 1'b1, 1'b1, 32'hBEEF0A09}) begin
            errors++;
            $display("FAIL raw10_w2: got vld=%b be=%b last=%b done=%b data=%h", pyld_vld, pyld_be, pyld_last, pkt_done, pyld_data);
        end
        checks++;
        if (crc_rcv !== 16'hBEEF) begin
            errors++;
            $display("FAIL raw10_crc: got %h want beef", crc_rcv);
        end
        drive(32'h0, 1'b0);
        checks++;
        if ({pyld_vld, pkt_done, trunc_err} !== 3'b000) begin
            errors++;
            $display("FAIL raw10_end: got %b want 000", {pyld_vld, pkt_done, trunc_err});
        end
        idle(1);
    endtask

    task automatic test_crc_boundary;
        // WC = 7: CRC low byte in lane3, high byte in next lane0.
        drive(H_WC7, 1'b1);
        drive(32'h44332211, 1'b1);
        drive(32'h34776655, 1'b1);
        drive(32'hAAAAAA12, 1'b1);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pkt_done} !== {1'b1, 4'b0111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wc7_last: got vld=%b be=%b last=%b done=%b want 1 0111 1 0", pyld_vld, pyld_be, pyld_last, pkt_done);
        end
        drive(32'h0, 1'b0);
        checks++;
        if ({pkt_done, pyld_vld, trunc_err, crc_rcv} !== {3'b100, 16'h1234}) begin
            errors++;
            $display("FAIL wc7_crc: got done=%b vld=%b trunc=%b crc=%h want 1 0 0 1234", pkt_done, pyld_vld, trunc_err, crc_rcv);
        end
        idle(2);
        // WC = 8: CRC in lanes 0/1 of the following word.
        drive(H_WC8, 1'b1);
        drive(32'h44332211, 1'b1);
        drive(32'h88776655, 1'b1);
        drive(32'h5555ABCD, 1'b1);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pkt_done} !== {1'b1, 4'b1111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wc8_last: got vld=%b be=%b last=%b done=%b want 1 1111 1 0", pyld_vld, pyld_be, pyld_last, pkt_done);
        end
        drive(32'h0, 1'b0);
        checks++;
        if ({pkt_done, pyld_vld, crc_rcv} !== {2'b10, 16'hABCD}) begin
            errors++;
            $display("FAIL wc8_crc: got done=%b vld=%b crc=%h want 1 0 abcd", pkt_done, pyld_vld, crc_rcv);
        end
        idle(2);
        // WC = 0: the word after the header is the CRC.
        drive(H_WC0, 1'b1);
        drive(32'h99991357, 1'b1);
        checks++;
        if ({hdr_vld, pkt_done, wc} !== {2'b10, 16'd0}) begin
            errors++;
            $display("FAIL wc0_hdr: got vld=%b done=%b wc=%h want 1 0 0000", hdr_vld, pkt_done, wc);
        end
        drive(32'h0, 1'b0);
        checks++;
        if ({pkt_done, pyld_vld, crc_rcv} !== {2'b10, 16'h1357}) begin
            errors++;
            $display("FAIL wc0_crc: got done=%b vld=%b crc=%h want 1 0 1357", pkt_done, pyld_vld, crc_rcv);
        end
        idle(2);
    endtask

    task automatic test_ecc;
        // Single data-bit error in DI bit 3: corrected, packet still parsed.
        drive(H_DI3, 1'b1);
        drive(32'h04030201, 1'b1);
        checks++;
        if ({hdr_vld, ecc_corr, ecc_err, vc, dt, wc} !== {3'b110, 2'd0, 6'h2B, 16'd10}) begin
            errors++;
            $display("FAIL ecc_corr_di3: got vld=%b corr=%b err=%b vc=%0d dt=%h wc=%0d", hdr_vld, ecc_corr, ecc_err, vc, dt, wc);
        end
        drive(32'h08070605, 1'b1);
        drive(32'hBEEF0A09, 1'b1);
        drive(32'h0, 1'b0);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pkt_done} !== {1'b1, 4'b0011, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ecc_corr_pyld: got vld=%b be=%b last=%b done=%b", pyld_vld, pyld_be, pyld_last, pkt_done);
        end
        idle(2);
        // Error in the ECC byte itself: flagged corrected, data untouched.
        drive(H_FS_EBIT, 1'b1);
        drive(32'h0, 1'b1);
        checks++;
        if ({hdr_vld, ecc_corr, ecc_err, sp, dt, wc} !== {4'b1101, 6'h00, 16'h0001}) begin
            errors++;
            $display("FAIL ecc_corr_eccbyte: got vld=%b corr=%b err=%b sp=%b dt=%h wc=%h", hdr_vld, ecc_corr, ecc_err, sp, dt, wc);
        end
        idle(2);
        // Double-bit error: uncorrectable, rest of burst ignored.
        drive(H_DBL, 1'b1);
        drive(32'h04030201, 1'b1);
        checks++;
        if ({hdr_vld, ecc_err, pkt_done, pyld_vld} !== 4'b1110) begin
            errors++;
            $display("FAIL ecc_err_hdr: got vld=%b err=%b done=%b pyld=%b want 1110", hdr_vld, ecc_err, pkt_done, pyld_vld);
        end
        drive(H_FS, 1'b1);
        drive(32'hBEEF0A09, 1'b1);
        drive(32'h11111111, 1'b1);
        drive(32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({hdr_vld, pyld_vld, pkt_done} !== 3'b000) begin
                errors++;
                $display("FAIL ecc_err_drain%0d: got %b want 000", i, {hdr_vld, pyld_vld, pkt_done});
            end
            drive(32'h0, 1'b0);
        end
        idle(1);
    endtask

    task automatic test_trunc;
        drive(H_WC16, 1'b1);
        drive(32'h04030201, 1'b1);
        drive(32'h08070605, 1'b1);
        drive(32'h0, 1'b0);
        checks++;
        if ({pyld_vld, pyld_be, pyld_last, pyld_data} !== {1'b1, 4'b1111, 1'b0, 32'h08070605}) begin
            errors++;
            $display("FAIL trunc_w1: got vld=%b be=%b last=%b data=%h", pyld_vld, pyld_be, pyld_last, pyld_data);
        end
        // Enable low for one cycle only, next burst starts straight away.
        drive(H_FS, 1'b1);
        checks++;
        if ({trunc_err, pkt_done, pyld_vld, pyld_last} !== 4'b1100) begin
            errors++;
            $display("FAIL trunc_pulse: got trunc=%b done=%b vld=%b last=%b want 1100", trunc_err, pkt_done, pyld_vld, pyld_last);
        end
        drive(32'h0, 1'b1);
        checks++;
        if ({hdr_vld, sp, pkt_done, trunc_err, wc} !== {4'b1110, 16'h0001}) begin
            errors++;
            $display("FAIL trunc_next: got vld=%b sp=%b done=%b trunc=%b wc=%h", hdr_vld, sp, pkt_done, trunc_err, wc);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        drive(H_RAW10, 1'b1);
        drive(32'h04030201, 1'b1);
        drive(32'h08070605, 1'b1);
        checks++;
        if (pyld_vld !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got pyld_vld=%b want 1", pyld_vld);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({hdr_vld, vc, dt, wc, sp, ecc_corr, ecc_err, pyld_data, pyld_be,
             pyld_vld, pyld_last, crc_rcv, pkt_done, trunc_err} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: outputs not cleared (pyld_vld=%b data=%h wc=%h)", pyld_vld, pyld_data, wc);
        end
        byte_en   = 1'b0;
        byte_data = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        drive(H_FS, 1'b1);
        drive(32'h0, 1'b1);
        checks++;
        if ({hdr_vld, sp, pkt_done, pyld_vld} !== 4'b1110) begin
            errors++;
            $display("FAIL rstmid_recover: got %b want 1110", {hdr_vld, sp, pkt_done, pyld_vld});
        end
        idle(2);
    endtask

`ifdef CSI2_RX_CRC_CHECK_EN
    // Reference CRC-16 over four bytes, LSB first, reflected polynomial.
    function automatic logic [15:0] crc_model(input logic [31:0] w);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ w[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic test_crc_check;
        logic [15:0] c;
        c = crc_model(32'h04030201);
        for (int n = 0; n < 2; n++) begin
            drive(H_WC4, 1'b1);
            drive((n == 0) ? 32'h04030201 : 32'h04030200, 1'b1);
            drive({16'h0000, c}, 1'b1);
            drive(32'h0, 1'b0);
            checks++;
            if ({pkt_done, crc_err, crc_rcv} !== {1'b1, (n == 1), c}) begin
                errors++;
                $display("FAIL crc_check%0d: got done=%b err=%b crc=%h want 1 %0d %h", n, pkt_done, crc_err, crc_rcv, n, c);
            end
            idle(2);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        byte_en   = 1'b0;
        byte_data = 32'h0;
        test_reset;
        test_short_fs;
        test_long_raw10;
        test_crc_boundary;
        test_ecc;
        test_trunc;
        test_reset_mid;
`ifdef CSI2_RX_CRC_CHECK_EN
        test_crc_check;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
